// File: rtl/branch_ctrl_if.sv
// ----------------------------------------------------------------------------
// branch_ctrl_if
//   Bundles the EX/MEM branch-resolution signals between the pipeline and the
//   branch control unit.
//
//   Pipeline -> unit : ex_valid, ex_opcode, ex_cond, ex_target, ex_loop_count,
//                      ex_ret_addr, flags {V,C,N,Z}
//   Unit -> pipeline : redirect, redirect_target, flush, ras_count,
//                      ras_overflow, ras_underflow
//
//   Modport master is the pipeline side and drives the instruction fields.
//   Modport slave is the branch control unit side.
// ----------------------------------------------------------------------------
interface branch_ctrl_if #(
    parameter int DW        = 8,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic          ex_valid;
    logic [3:0]    ex_opcode;
    logic [1:0]    ex_cond;
    logic [DW-1:0] ex_target;
    logic [DW-1:0] ex_loop_count;
    logic [DW-1:0] ex_ret_addr;
    logic [3:0]    flags;

    logic          redirect;
    logic [DW-1:0] redirect_target;
    logic          flush;
    logic [CW-1:0] ras_count;
    logic          ras_overflow;
    logic          ras_underflow;

    modport master (
        output ex_valid, ex_opcode, ex_cond, ex_target, ex_loop_count,
               ex_ret_addr, flags,
        input  redirect, redirect_target, flush, ras_count,
               ras_overflow, ras_underflow
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_cond, ex_target, ex_loop_count,
               ex_ret_addr, flags,
        output redirect, redirect_target, flush, ras_count,
               ras_overflow, ras_underflow
    );
endinterface

// File: rtl/branch_ctrl_unit.sv
// ----------------------------------------------------------------------------
// branch_ctrl_unit
//   Registered branch resolution at the EX/MEM boundary. Decodes the branch
//   instruction against the flags, the LOOP count and the target, then issues
//   a one-cycle redirect pulse and a FLUSH_CYCLES-long pipeline flush. A small
//   circular return-address stack serves CALL (push) and RET (pop).
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    branch_ctrl_if.slave: instruction fields and flags in;
//            redirect, redirect_target, flush, ras_count and the sticky
//            ras_overflow / ras_underflow bits out (all registered)
// ----------------------------------------------------------------------------
module branch_ctrl_unit #(
    parameter int DW           = 8,
    parameter int RAS_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    branch_ctrl_if.slave   bus
);
    localparam int PW  = $clog2(RAS_DEPTH);
    localparam int CW  = PW + 1;
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [CW-1:0]  RAS_FULL   = CW'(RAS_DEPTH);
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE,
        FLUSHING
    } state_t;

    state_t         state;
    logic [FCW-1:0] flush_cnt;
    logic [DW-1:0]  ras_mem [RAS_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  ras_cnt;

    logic           redirect_q;
    logic [DW-1:0]  redirect_target_q;
    logic           flush_q;
    logic           overflow_q;
    logic           underflow_q;

    logic           taken;
    logic [DW-1:0]  next_target;
    logic           do_push;
    logic           do_pop;

    // Decode is only honoured in IDLE; anything arriving during a flush is
    // wrong-path and must not touch the RAS or the redirect path.
    always_comb begin
        taken       = 1'b0;
        next_target = '0;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        if (bus.ex_valid && state == IDLE) begin
            case (bus.ex_opcode)
                4'h9: begin
                    // flags is {V,C,N,Z}, so cond 00..11 selects Z,N,C,V directly
                    taken       = bus.flags[bus.ex_cond];
                    next_target = bus.ex_target;
                end
                4'hA: begin
                    taken       = (bus.ex_loop_count != '0);
                    next_target = bus.ex_target;
                end
                4'hB: begin
                    case (bus.ex_cond)
                        2'b00: begin
                            taken       = 1'b1;
                            next_target = bus.ex_target;
                        end
                        2'b01: begin
                            taken       = 1'b1;
                            next_target = bus.ex_target;
                            do_push     = 1'b1;
                        end
                        2'b10: begin
                            taken  = 1'b1;
                            do_pop = 1'b1;
                            if (ras_cnt != '0) begin
                                next_target = ras_mem[wr_ptr - PW'(1)];
                            end
                        end
                        default: begin
                            taken = 1'b0;
                        end
                    endcase
                end
                default: begin
                    taken = 1'b0;
                end
            endcase
        end
    end

    // Flush FSM, redirect registers and return-address stack. The RAS is a
    // circular buffer: a push onto a full stack overwrites the oldest entry
    // simply by letting wr_ptr wrap, while the count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            flush_cnt         <= '0;
            wr_ptr            <= '0;
            ras_cnt           <= '0;
            redirect_q        <= 1'b0;
            redirect_target_q <= '0;
            flush_q           <= 1'b0;
            overflow_q        <= 1'b0;
            underflow_q       <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            redirect_q        <= 1'b0;
            redirect_target_q <= '0;

            case (state)
                IDLE: begin
                    if (taken) begin
                        redirect_q        <= 1'b1;
                        redirect_target_q <= next_target;
                        flush_q           <= 1'b1;
                        flush_cnt         <= FLUSH_LOAD;
                        state             <= FLUSHING;
                    end
                end
                FLUSHING: begin
                    if (flush_cnt == '0) begin
                        flush_q <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - FCW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (do_push) begin
                ras_mem[wr_ptr] <= bus.ex_ret_addr;
                wr_ptr          <= wr_ptr + PW'(1);
                if (ras_cnt == RAS_FULL) begin
                    overflow_q <= 1'b1;
                end else begin
                    ras_cnt <= ras_cnt + CW'(1);
                end
            end else if (do_pop) begin
                if (ras_cnt != '0) begin
                    wr_ptr  <= wr_ptr - PW'(1);
                    ras_cnt <= ras_cnt - CW'(1);
                end else begin
                    underflow_q <= 1'b1;
                end
            end
        end
    end

    assign bus.redirect        = redirect_q;
    assign bus.redirect_target = redirect_target_q;
    assign bus.flush           = flush_q;
    assign bus.ras_count       = ras_cnt;
    assign bus.ras_overflow    = overflow_q;
    assign bus.ras_underflow   = underflow_q;
endmodule

// File: tb/tb_branch_ctrl_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_ctrl_unit
//   Directed bench for branch_ctrl_unit (DW=8, RAS_DEPTH=4, FLUSH_CYCLES=2).
//   Every expected redirect target is queued before its instruction is
//   issued; a monitor pops the queue whenever redirect is seen high.
//   Flush timing, RAS occupancy and sticky bits are checked inline.
// ----------------------------------------------------------------------------
module tb_branch_ctrl_unit;
    localparam int DW = 8;
    localparam int RD = 4;

    logic clk;
    logic rst_n;

    branch_ctrl_if #(.DW(DW), .RAS_DEPTH(RD)) bus ();

    branch_ctrl_unit #(.DW(DW), .RAS_DEPTH(RD), .FLUSH_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors      = 0;
    int checks      = 0;
    int pulse_count = 0;
    logic [DW-1:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: present one instruction for a single cycle and
    // return at the negedge after the capturing edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [1:0] cond,
                                 input logic [DW-1:0] tgt, input logic [DW-1:0] loop,
                                 input logic [DW-1:0] ret, input logic [3:0] fl);
        bus.ex_valid      = 1'b1;
        bus.ex_opcode     = op;
        bus.ex_cond       = cond;
        bus.ex_target     = tgt;
        bus.ex_loop_count = loop;
        bus.ex_ret_addr   = ret;
        bus.flags         = fl;
        @(negedge clk);
        bus.ex_valid = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 20 && bus.flush; i++) @(negedge clk);
        checkOutput("flush_drain", {31'b0, bus.flush}, 32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && bus.redirect) begin
            pulse_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_redirect", 32'd1, 32'd0);
            end else begin
                checkOutput("redirect_target", {24'b0, bus.redirect_target},
                            {24'b0, exp_q.pop_front()});
            end
        end
    end

    int pulses_before;

    initial begin
        rst_n             = 1'b0;
        bus.ex_valid      = 1'b0;
        bus.ex_opcode     = '0;
        bus.ex_cond       = '0;
        bus.ex_target     = '0;
        bus.ex_loop_count = '0;
        bus.ex_ret_addr   = '0;
        bus.flags         = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_redirect", {31'b0, bus.redirect}, 32'd0);
        checkOutput("reset_flush", {31'b0, bus.flush}, 32'd0);
        checkOutput("reset_ras_count", {29'b0, bus.ras_count}, 32'd0);
        checkOutput("reset_sticky", {30'b0, bus.ras_overflow, bus.ras_underflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // BEQ taken with Z=1
        exp_q.push_back(8'h40);
        applyStimulus(4'h9, 2'b00, 8'h40, 8'h00, 8'h00, 4'b0001);
        checkOutput("beq_redirect", {31'b0, bus.redirect}, 32'd1);
        checkOutput("beq_flush_c1", {31'b0, bus.flush}, 32'd1);
        @(negedge clk);
        checkOutput("beq_redirect_one_cycle", {31'b0, bus.redirect}, 32'd0);
        checkOutput("beq_flush_c2", {31'b0, bus.flush}, 32'd1);
        @(negedge clk);
        checkOutput("beq_flush_end", {31'b0, bus.flush}, 32'd0);

        // Carry condition with C=0: not taken
        applyStimulus(4'h9, 2'b10, 8'h55, 8'h00, 8'h00, 4'b1011);
        checkOutput("bc_not_taken", {31'b0, bus.redirect}, 32'd0);
        checkOutput("bc_no_flush", {31'b0, bus.flush}, 32'd0);
        checkOutput("bc_target_zero", {24'b0, bus.redirect_target}, 32'd0);

        // Negative condition with N=1: taken
        exp_q.push_back(8'h23);
        applyStimulus(4'h9, 2'b01, 8'h23, 8'h00, 8'h00, 4'b0010);
        checkOutput("bn_taken", {31'b0, bus.redirect}, 32'd1);
        waitIdle();

        // LOOP with zero then non-zero count
        applyStimulus(4'hA, 2'b00, 8'h66, 8'h00, 8'h00, 4'b1111);
        checkOutput("loop0_not_taken", {31'b0, bus.redirect}, 32'd0);
        exp_q.push_back(8'h66);
        applyStimulus(4'hA, 2'b00, 8'h66, 8'h01, 8'h00, 4'b0000);
        checkOutput("loop1_taken", {31'b0, bus.redirect}, 32'd1);
        waitIdle();

        // RTI and a non-branch opcode are never taken
        applyStimulus(4'hB, 2'b11, 8'h77, 8'h01, 8'h00, 4'b1111);
        checkOutput("rti_not_taken", {31'b0, bus.redirect}, 32'd0);
        applyStimulus(4'h3, 2'b00, 8'h77, 8'h01, 8'h00, 4'b1111);
        checkOutput("alu_not_taken", {31'b0, bus.redirect}, 32'd0);

        // CALL then RET
        exp_q.push_back(8'h80);
        applyStimulus(4'hB, 2'b01, 8'h80, 8'h00, 8'h11, 4'b0000);
        checkOutput("call_ras_count", {29'b0, bus.ras_count}, 32'd1);
        waitIdle();
        exp_q.push_back(8'h11);
        applyStimulus(4'hB, 2'b10, 8'hFF, 8'h00, 8'h00, 4'b0000);
        checkOutput("ret_ras_count", {29'b0, bus.ras_count}, 32'd0);
        waitIdle();

        // Five CALLs into a four-deep RAS
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(8'h90 + i));
            applyStimulus(4'hB, 2'b01, 8'(8'h90 + i), 8'h00, 8'(i), 4'b0000);
            if (i == 4) checkOutput("no_overflow_at_full", {31'b0, bus.ras_overflow}, 32'd0);
            waitIdle();
        end
        checkOutput("overflow_count", {29'b0, bus.ras_count}, 32'd4);
        checkOutput("overflow_sticky", {31'b0, bus.ras_overflow}, 32'd1);

        for (int i = 5; i >= 2; i--) begin
            exp_q.push_back(8'(i));
            applyStimulus(4'hB, 2'b10, 8'hFF, 8'h00, 8'h00, 4'b0000);
            checkOutput("pop_count", {29'b0, bus.ras_count}, 32'(i - 2));
            waitIdle();
        end
        checkOutput("no_underflow_yet", {31'b0, bus.ras_underflow}, 32'd0);
        exp_q.push_back(8'h00);
        applyStimulus(4'hB, 2'b10, 8'hFF, 8'h00, 8'h00, 4'b0000);
        checkOutput("underflow_sticky", {31'b0, bus.ras_underflow}, 32'd1);
        checkOutput("underflow_count", {29'b0, bus.ras_count}, 32'd0);
        waitIdle();

        // JMP, then JMPs presented during the flush are ignored
        pulses_before = pulse_count;
        exp_q.push_back(8'hA5);
        applyStimulus(4'hB, 2'b00, 8'hA5, 8'h00, 8'h00, 4'b0000);
        applyStimulus(4'hB, 2'b00, 8'h5A, 8'h00, 8'h00, 4'b0000);
        applyStimulus(4'hB, 2'b01, 8'h5B, 8'h00, 8'h44, 4'b0000);
        @(negedge clk);
        checkOutput("flush_single_pulse", 32'(pulse_count - pulses_before), 32'd1);
        checkOutput("flush_no_push", {29'b0, bus.ras_count}, 32'd0);
        waitIdle();

        // Reset in the first flush cycle of a CALL
        exp_q.push_back(8'h77);
        applyStimulus(4'hB, 2'b01, 8'h77, 8'h00, 8'h33, 4'b0000);
        checkOutput("pre_reset_flush", {31'b0, bus.flush}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_flush", {31'b0, bus.flush}, 32'd0);
        checkOutput("async_reset_redirect", {31'b0, bus.redirect}, 32'd0);
        checkOutput("async_reset_ras_count", {29'b0, bus.ras_count}, 32'd0);
        checkOutput("async_reset_sticky", {30'b0, bus.ras_overflow, bus.ras_underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
